// File: rtl/ext_pkg.sv
// Shared constants for the immediate extender: extension-mode encodings and default widths.
// Optional LUI support is selected with the EXT_LUI_EN macro (see ext_comb / ext_unit).
package ext_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;

endpackage

// File: rtl/ext_comb.sv
// Pure combinational immediate extender: zero- or sign-extends Input to OUT_W bits.
// With EXT_LUI_EN defined, LuiOp=1 places Input in the upper bits instead (overrides ExtOp).
module ext_comb
  import ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             ExtOp,
`ifdef EXT_LUI_EN
  input  logic             LuiOp,
`endif
  input  logic [IN_W-1:0]  Input,
  output logic [OUT_W-1:0] Output
);

  always_comb begin
    Output = {{(OUT_W-IN_W){1'b0}}, Input};
    case (ExtOp)
      EXT_ZERO: Output = {{(OUT_W-IN_W){1'b0}}, Input};
      EXT_SIGN: Output = {{(OUT_W-IN_W){Input[IN_W-1]}}, Input};
      default:  Output = {{(OUT_W-IN_W){1'b0}}, Input};
    endcase
`ifdef EXT_LUI_EN
    if (LuiOp) begin
      Output = {Input, {(OUT_W-IN_W){1'b0}}};
    end
`endif
  end

endmodule

// File: rtl/ext_unit.sv
// Immediate extender with a same-cycle combinational result and a one-cycle registered copy.
// Optional LUI mode is enabled by the EXT_LUI_EN macro (adds the LuiOp input).
module ext_unit
  import ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ExtOp,
`ifdef EXT_LUI_EN
  input  logic             LuiOp,
`endif
  input  logic [IN_W-1:0]  Input,
  input  logic             in_valid,
  output logic [OUT_W-1:0] Output,
  output logic [OUT_W-1:0] Output_q,
  output logic             out_valid
);

  ext_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_comb (
    .ExtOp  (ExtOp),
`ifdef EXT_LUI_EN
    .LuiOp  (LuiOp),
`endif
    .Input  (Input),
    .Output (Output)
  );

  // Valid-only handshake (no ready): every cycle with in_valid=1 is captured, and
  // out_valid is high for exactly the cycle after capture; Output_q holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      Output_q  <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      Output_q  <= Output;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ext_unit.sv
// Self-checking bench for ext_unit: directed spec vectors plus randomized traffic
// checked against an arithmetic reference model and an expected-result queue.
module tb_ext_unit;

`ifdef EXT_LUI_EN
  localparam bit LUI_EN = 1'b1;
`else
  localparam bit LUI_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ExtOp;
  logic        LuiOp;
  logic [15:0] Input;
  logic        in_valid;
  logic [31:0] Output;
  logic [31:0] Output_q;
  logic        out_valid;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [31:0] model_q;
  logic        model_v;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ext_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ExtOp     (ExtOp),
`ifdef EXT_LUI_EN
    .LuiOp     (LuiOp),
`endif
    .Input     (Input),
    .in_valid  (in_valid),
    .Output    (Output),
    .Output_q  (Output_q),
    .out_valid (out_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // reference model: extension expressed as integer arithmetic
  function automatic logic [31:0] ref_ext(input logic op, input logic [15:0] imm, input logic lui);
    int v;
    if (LUI_EN && lui) return imm * 32'd65536;
    if (op) begin
      v = $signed(imm);
      return 32'(v);
    end
    return 32'(imm);
  endfunction

  // driver: apply one cycle of inputs (called #1 after a posedge), check both outputs
  task automatic step(input logic rst, input logic op, input logic [15:0] imm,
                      input logic vld, input logic lui);
    logic [31:0] e;
    logic [31:0] front;
    reset = rst; ExtOp = op; Input = imm; in_valid = vld; LuiOp = lui;
    #1;
    e = ref_ext(op, imm, lui);
    check_eq("comb_out", Output, e);
    if (rst) begin
      model_q = '0; model_v = 1'b0; exp_q.delete();
    end else if (vld) begin
      model_q = e; model_v = 1'b1; exp_q.push_back(e);
    end else begin
      model_v = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, model_v});
    if (model_v && exp_q.size() > 0) begin
      front = exp_q.pop_front();
      check_eq("sb_out_q", Output_q, front);
    end
    check_eq("held_out_q", Output_q, model_q);
  endtask

  typedef struct {
    logic        op;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    n_checks = 0; n_fail = 0;
    model_q = '0; model_v = 1'b0;
    reset = 1'b1; ExtOp = 1'b0; LuiOp = 1'b0; Input = '0; in_valid = 1'b0;

    vecs[0] = '{1'b0, 16'h0000, 32'h00000000};
    vecs[1] = '{1'b0, 16'd10,   32'h0000000A};
    vecs[2] = '{1'b0, 16'hFFFF, 32'h0000FFFF};
    vecs[3] = '{1'b1, 16'd10,   32'h0000000A};
    vecs[4] = '{1'b1, 16'hFFF6, 32'hFFFFFFF6};
    vecs[5] = '{1'b1, 16'h8000, 32'hFFFF8000};
    vecs[6] = '{1'b0, 16'h7FFF, 32'h00007FFF};
    vecs[7] = '{1'b1, 16'h7FFF, 32'h00007FFF};

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_q", Output_q, 32'h0);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);

    // directed spec constants, combinational (reset still held: output must track)
    foreach (vecs[i]) begin
      ExtOp = vecs[i].op; Input = vecs[i].imm;
      #1;
      check_eq($sformatf("dir_%0d", i), Output, vecs[i].exp);
    end
    @(posedge clk); #1;

    // release reset, then edge-N capture of 16'h8000 sign-extended, then idle
    step(1'b0, 1'b1, 16'h8000, 1'b1, 1'b0);
    check_eq("edgeN_out_q", Output_q, 32'hFFFF8000);
    step(1'b0, 1'b0, 16'h1111, 1'b0, 1'b0);
    check_eq("edgeN1_valid", {31'b0, out_valid}, 32'h0);

    // reset with in_valid drops the value
    step(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0);
    check_eq("rstv_out_q", Output_q, 32'h0);

    // back-to-back captures, first after reset
    foreach (vecs[i]) step(1'b0, vecs[i].op, vecs[i].imm, 1'b1, 1'b0);

`ifdef EXT_LUI_EN
    LuiOp = 1'b1; ExtOp = 1'b1; Input = 16'h1234;
    #1;
    check_eq("lui", Output, 32'h12340000);
    step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
`endif

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 65535)), 1'($urandom_range(0, 2) != 0),
           LUI_EN ? 1'($urandom_range(0, 3) == 0) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
